id_operand_stage: RTL
=====================

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 SHALL have parameter N_FWD, default 2, number of bypass sources; index 0 is the youngest (EX), higher indices are older (MEM, WB...).
REQ-002 SHALL have parameter N_STALL_CNT, default 16, width of the stall-cycle counter.
REQ-003 SHALL have parameters N_REG (32), N_REG_ADDR (5), N_ALU_OP (8) and N_ALU_SEL (3), all defaulting to the shared package values.
REQ-004 SHALL have the ports below, one per line: name  direction  width  meaning.
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_valid  in  1  upstream holds a decoded instruction.
- o_ready  out  1  stage accepts the upstream instruction this cycle.
- i_flush  in  1  kill the stage contents and the input.
- i_alu_op / i_alu_sel  in  N_ALU_OP / N_ALU_SEL  decoded operation.
- i_reg0_ren, i_reg1_ren  in  1 each  operand read enables.
- i_reg0_addr, i_reg1_addr  in  N_REG_ADDR each  operand addresses.
- i_imm  in  N_REG  immediate, used when the matching ren is 0.
- i_wen / i_waddr  in  1 / N_REG_ADDR  destination register.
- o_reg0_addr, o_reg1_addr, o_reg0_ren, o_reg1_ren  out  regfile read request; combinational pass-through of the inputs.
- i_reg0_data, i_reg1_data  in  N_REG each  regfile read data, same cycle.
- i_fwd_wen  in  N_FWD  per-source write enable.
- i_fwd_waddr  in  N_FWD x N_REG_ADDR  per-source destination.
- i_fwd_wdata  in  N_FWD x N_REG  per-source result.
- i_fwd_rdy  in  N_FWD  per-source result is valid now; 0 means load or multicycle not yet done.
- o_valid  out  1  the EX-side register holds an instruction.
- i_ex_ready  in  1  EX accepts the instruction.
- o_alu_op, o_alu_sel, o_op0, o_op1, o_wen, o_waddr  out  registered outputs to EX.
- o_stall  out  1  hazard interlock active this cycle.
- o_stall_cnt  out  N_STALL_CNT  count of stall cycles, saturating.

Function
REQ-005 Operand selection SHALL be evaluated per operand: if ren is 0, take i_imm; else if addr is 0, take 0 and never bypass; else take the matching source with the lowest index k that has wen[k]=1 and waddr[k]=addr; if none matches, take the regfile data.
REQ-006 A hazard SHALL exist when the selected bypass source has fwd_rdy=0; older matching sources SHALL be ignored in that case.
REQ-007 o_stall SHALL be asserted when i_valid=1, a hazard exists and i_flush=0.
REQ-008 o_ready SHALL equal !o_stall && (!o_valid || i_ex_ready).
REQ-009 An instruction SHALL be accepted when i_valid && o_ready; the output register then loads the selected operands and control, and o_valid=1 on the next edge; latency is 1 cycle.
REQ-010 The FSM SHALL have three states: EMPTY (o_valid=0), FULL (o_valid=1) and HOLD (o_valid=1, i_ex_ready=0).
- In HOLD the outputs SHALL stay stable.
- A stall with a free output SHALL insert a bubble: o_valid goes to 0 and o_wen to 0.
REQ-011 FULL with i_ex_ready=1 and no accept SHALL go to EMPTY; FULL with i_ex_ready=0 SHALL go to HOLD; HOLD with i_ex_ready=1 SHALL follow the FULL rules.
REQ-012 i_flush SHALL clear o_valid and o_wen on the next edge, block acceptance that cycle and override a stall; the counter SHALL not increment.
REQ-013 o_stall_cnt SHALL increment by 1 each cycle o_stall=1 and saturate at all-ones.
REQ-014 Simultaneous i_ex_ready=1 and accept SHALL replace the output register in the same edge with no bubble.

Reset
REQ-015 On i_rst=1, immediately and asynchronously: o_valid=0, o_wen=0, o_waddr=0, o_alu_op=EXE_NOP_OP, o_alu_sel=EXE_RES_NOP, o_op0=0, o_op1=0, o_stall_cnt=0, FSM=EMPTY.
REQ-016 Reset mid-stall or in HOLD SHALL discard the held instruction; operation SHALL resume on the first edge after deassertion.

Structure
REQ-017 The shared package SHALL hold the width constants, EXE_NOP_OP, EXE_RES_NOP and the FSM state enum type.
REQ-018 Per-operand selection SHALL be one sub-module, id_opnd_sel, instantiated twice, which outputs the operand value and a hazard flag.

Verification
REQ-019 Bypass priority: reg0 addr 3; source 0 writes 3 with 0xAAAA_0000; source 1 writes 3 with 0x5555; regfile returns 0x1 -> o_op0=0xAAAA_0000 one cycle later.
REQ-020 Zero register: addr 0; source 0 writes 0 with 0xFFFF_FFFF -> o_op0=0.
REQ-021 Load-use: source 0 matches with fwd_rdy=0 for 2 cycles -> o_stall=1 for 2 cycles, two bubbles, o_stall_cnt=2, then acceptance with the forwarded data.
REQ-022 Backpressure: i_ex_ready=0 for 3 cycles while FULL -> outputs stable, o_ready=0; on release, next instruction accepted with no bubble.
REQ-023 Flush during stall: i_flush=1 -> o_valid=0 next edge, o_stall=0, counter unchanged.
REQ-024 Async reset: assert i_rst between edges in HOLD -> o_valid=0 immediately, o_stall_cnt=0.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared widths, reset encodings and the output-register state type for the
// decode-stage operand selector.
package id_operand_stage_pkg;

   localparam int PKG_N_REG      = 32;
   localparam int PKG_N_REG_ADDR = 5;
   localparam int PKG_N_ALU_OP   = 8;
   localparam int PKG_N_ALU_SEL  = 3;

   localparam logic [PKG_N_ALU_OP-1:0]  EXE_NOP_OP  = 8'h00;
   localparam logic [PKG_N_ALU_SEL-1:0] EXE_RES_NOP = 3'b000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HOLD  = 2'd2
   } stage_state_t;

endpackage

// File: rtl/id_operand_stage_opnd_sel.sv
// Single-operand source selection: immediate, hard-wired zero, youngest
// matching bypass source, or regfile data, plus a not-ready hazard flag.
module id_opnd_sel
   import id_operand_stage_pkg::*;
#(
   parameter int N_FWD      = 2,
   parameter int N_REG      = PKG_N_REG,
   parameter int N_REG_ADDR = PKG_N_REG_ADDR
) (
   input  logic                          i_ren,
   input  logic [N_REG_ADDR-1:0]         i_addr,
   input  logic [N_REG-1:0]              i_imm,
   input  logic [N_REG-1:0]              i_rf_data,
   input  logic [N_FWD-1:0]              i_fwd_wen,
   input  logic [N_FWD*N_REG_ADDR-1:0]   i_fwd_waddr,
   input  logic [N_FWD*N_REG-1:0]        i_fwd_wdata,
   input  logic [N_FWD-1:0]              i_fwd_rdy,
   output logic [N_REG-1:0]              o_data,
   output logic                          o_hazard
);

   logic             w_hit;
   logic             w_hit_rdy;
   logic [N_REG-1:0] w_hit_data;

   // Scan oldest to youngest so the lowest matching index wins; older matches
   // behind a not-ready young source are shadowed.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_rdy  = 1'b1;
      w_hit_data = i_rf_data;
      for (int k = N_FWD - 1; k >= 0; k--) begin
         if (i_fwd_wen[k] && (i_fwd_waddr[k*N_REG_ADDR +: N_REG_ADDR] == i_addr)) begin
            w_hit      = 1'b1;
            w_hit_rdy  = i_fwd_rdy[k];
            w_hit_data = i_fwd_wdata[k*N_REG +: N_REG];
         end else begin
            w_hit      = w_hit;
         end
      end
   end

   // Final operand mux; register 0 reads as zero and never bypasses.
   always_comb begin
      o_data   = '0;
      o_hazard = 1'b0;
      if (!i_ren) begin
         o_data   = i_imm;
         o_hazard = 1'b0;
      end else if (i_addr == '0) begin
         o_data   = '0;
         o_hazard = 1'b0;
      end else begin
         o_data   = w_hit_data;
         o_hazard = w_hit & ~w_hit_rdy;
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-side operand stage: bypass selection, load-use interlock and a
// one-entry output register toward EX with valid/ready handshaking.
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int N_FWD       = 2,
   parameter int N_STALL_CNT = 16,
   parameter int N_REG       = PKG_N_REG,
   parameter int N_REG_ADDR  = PKG_N_REG_ADDR,
   parameter int N_ALU_OP    = PKG_N_ALU_OP,
   parameter int N_ALU_SEL   = PKG_N_ALU_SEL
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic                          i_flush,
   input  logic [N_ALU_OP-1:0]           i_alu_op,
   input  logic [N_ALU_SEL-1:0]          i_alu_sel,
   input  logic                          i_reg0_ren,
   input  logic                          i_reg1_ren,
   input  logic [N_REG_ADDR-1:0]         i_reg0_addr,
   input  logic [N_REG_ADDR-1:0]         i_reg1_addr,
   input  logic [N_REG-1:0]              i_imm,
   input  logic                          i_wen,
   input  logic [N_REG_ADDR-1:0]         i_waddr,
   output logic [N_REG_ADDR-1:0]         o_reg0_addr,
   output logic [N_REG_ADDR-1:0]         o_reg1_addr,
   output logic                          o_reg0_ren,
   output logic                          o_reg1_ren,
   input  logic [N_REG-1:0]              i_reg0_data,
   input  logic [N_REG-1:0]              i_reg1_data,
   input  logic [N_FWD-1:0]              i_fwd_wen,
   input  logic [N_FWD*N_REG_ADDR-1:0]   i_fwd_waddr,
   input  logic [N_FWD*N_REG-1:0]        i_fwd_wdata,
   input  logic [N_FWD-1:0]              i_fwd_rdy,
   output logic                          o_valid,
   input  logic                          i_ex_ready,
   output logic [N_ALU_OP-1:0]           o_alu_op,
   output logic [N_ALU_SEL-1:0]          o_alu_sel,
   output logic [N_REG-1:0]              o_op0,
   output logic [N_REG-1:0]              o_op1,
   output logic                          o_wen,
   output logic [N_REG_ADDR-1:0]         o_waddr,
   output logic                          o_stall,
   output logic [N_STALL_CNT-1:0]        o_stall_cnt
);

   localparam logic [N_STALL_CNT-1:0] CNT_ONE = {{(N_STALL_CNT-1){1'b0}}, 1'b1};

   stage_state_t           r_state;
   stage_state_t           w_state_nxt;
   logic [N_ALU_OP-1:0]    r_alu_op;
   logic [N_ALU_SEL-1:0]   r_alu_sel;
   logic [N_REG-1:0]       r_op0;
   logic [N_REG-1:0]       r_op1;
   logic                   r_wen;
   logic [N_REG_ADDR-1:0]  r_waddr;
   logic [N_STALL_CNT-1:0] r_stall_cnt;

   logic [N_REG-1:0]       w_op0;
   logic [N_REG-1:0]       w_op1;
   logic                   w_haz0;
   logic                   w_haz1;
   logic                   w_valid;
   logic                   w_stall;
   logic                   w_ready;
   logic                   w_accept;
   logic                   w_load;
   logic                   w_drop;

   assign o_reg0_addr = i_reg0_addr;
   assign o_reg1_addr = i_reg1_addr;
   assign o_reg0_ren  = i_reg0_ren;
   assign o_reg1_ren  = i_reg1_ren;

   id_opnd_sel #(
      .N_FWD      (N_FWD),
      .N_REG      (N_REG),
      .N_REG_ADDR (N_REG_ADDR)
   ) u_sel0 (
      .i_ren       (i_reg0_ren),
      .i_addr      (i_reg0_addr),
      .i_imm       (i_imm),
      .i_rf_data   (i_reg0_data),
      .i_fwd_wen   (i_fwd_wen),
      .i_fwd_waddr (i_fwd_waddr),
      .i_fwd_wdata (i_fwd_wdata),
      .i_fwd_rdy   (i_fwd_rdy),
      .o_data      (w_op0),
      .o_hazard    (w_haz0)
   );

   id_opnd_sel #(
      .N_FWD      (N_FWD),
      .N_REG      (N_REG),
      .N_REG_ADDR (N_REG_ADDR)
   ) u_sel1 (
      .i_ren       (i_reg1_ren),
      .i_addr      (i_reg1_addr),
      .i_imm       (i_imm),
      .i_rf_data   (i_reg1_data),
      .i_fwd_wen   (i_fwd_wen),
      .i_fwd_waddr (i_fwd_waddr),
      .i_fwd_wdata (i_fwd_wdata),
      .i_fwd_rdy   (i_fwd_rdy),
      .o_data      (w_op1),
      .o_hazard    (w_haz1)
   );

   // Flush overrides the interlock and also blocks acceptance in its cycle.
   assign w_valid  = (r_state != ST_EMPTY);
   assign w_stall  = i_valid & (w_haz0 | w_haz1) & ~i_flush;
   assign w_ready  = ~w_stall & (~w_valid | i_ex_ready);
   assign w_accept = i_valid & w_ready & ~i_flush;

   // Next-state and load/drop decode for the output register.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      if (i_flush) begin
         w_state_nxt = ST_EMPTY;
         w_drop      = 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = ST_EMPTY;
                  w_drop      = 1'b1;
               end
            end
            ST_FULL, ST_HOLD: begin
               if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_load      = 1'b1;
               end else if (i_ex_ready) begin
                  w_state_nxt = ST_EMPTY;
                  w_drop      = 1'b1;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_drop      = 1'b1;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output register toward EX; a bubble only clears the write enable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_alu_op  <= EXE_NOP_OP;
         r_alu_sel <= EXE_RES_NOP;
         r_op0     <= '0;
         r_op1     <= '0;
         r_wen     <= 1'b0;
         r_waddr   <= '0;
      end else if (w_load) begin
         r_alu_op  <= i_alu_op;
         r_alu_sel <= i_alu_sel;
         r_op0     <= w_op0;
         r_op1     <= w_op1;
         r_wen     <= i_wen;
         r_waddr   <= i_waddr;
      end else if (w_drop) begin
         r_wen     <= 1'b0;
      end else begin
         r_wen     <= r_wen;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {N_STALL_CNT{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign o_valid     = w_valid;
   assign o_ready     = w_ready;
   assign o_stall     = w_stall;
   assign o_alu_op    = r_alu_op;
   assign o_alu_sel   = r_alu_sel;
   assign o_op0       = r_op0;
   assign o_op1       = r_op1;
   assign o_wen       = r_wen;
   assign o_waddr     = r_waddr;
   assign o_stall_cnt = r_stall_cnt;

endmodule
